// File: rtl/mod_addsub_ws_pkg.sv
// Shared definitions for the word-serial modular add/subtract block.
//   state_t   : controller state encoding
//   DEF_K     : default word width in bits
//   DEF_N     : default number of words per operand
//   cnt_width : width of the word counter for a given word count
package mod_addsub_ws_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DECIDE,
      OUT
   } state_t;

   localparam int unsigned DEF_K = 128;
   localparam int unsigned DEF_N = 32;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mod_addsub_word.sv
// One K-bit add/subtract slice with chained carry/borrow.
//   a, b : operand words
//   sub  : 0 -> a + b + cin, 1 -> a - b - cin
//   cin  : incoming carry (add) or borrow (sub)
//   sum  : K-bit result word
//   cout : outgoing carry (add) or borrow (sub)
module mod_addsub_word #(
   parameter int unsigned K = 128
) (
   input  logic [K-1:0] a,
   input  logic [K-1:0] b,
   input  logic         sub,
   input  logic         cin,
   output logic [K-1:0] sum,
   output logic         cout
);

   logic [K:0] t;

   // In K+1 bits a negative difference wraps with bit K set, so bit K
   // serves as both carry-out (add) and borrow-out (sub).
   always_comb begin
      if (sub) t = {1'b0, a} - {1'b0, b} - {{K{1'b0}}, cin};
      else     t = {1'b0, a} + {1'b0, b} + {{K{1'b0}}, cin};
   end

   assign sum  = t[K-1:0];
   assign cout = t[K];

endmodule

// File: rtl/mod_addsub_ws.sv
// Word-serial modular adder/subtractor: computes (x+y) mod m or (x-y) mod m
// on K*N-bit operands streamed one K-bit word per accepted cycle, LS first.
//   clk, rst          : clock, synchronous active-high reset
//   start, op_sub     : begin operation, mode (0 add, 1 sub) sampled on start
//   in_x, in_y, in_m  : operand words, qualified by in_valid
//   out_result        : result word stream, zero when out_valid is low
//   out_valid/out_last: result word valid / final result word
//   busy              : controller not idle
module mod_addsub_ws
   import mod_addsub_ws_pkg::*;
#(
   parameter int unsigned K = DEF_K,
   parameter int unsigned N = DEF_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         op_sub,
   input  logic [K-1:0] in_x,
   input  logic [K-1:0] in_y,
   input  logic [K-1:0] in_m,
   input  logic         in_valid,
   output logic [K-1:0] out_result,
   output logic         out_valid,
   output logic         out_last,
   output logic         busy
);

   localparam int unsigned CW = cnt_width(N);

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic          mode;
   logic          c_s;      // c1 (add) or b1 (sub) chained on the s path
   logic          c_d;      // b2 (add) or c2 (sub) chained on the d path
   logic          sel;      // 1 selects the d buffer for output
   logic          last_cnt;
   logic          consume;
   logic          d_sub;

   logic [K-1:0]  s_word, d_word;
   logic          s_co, d_co;

   logic [K-1:0]  s_buf [N];
   logic [K-1:0]  d_buf [N];

   assign last_cnt = (cnt == CW'(N - 1));
   assign consume  = (state == LOAD) && in_valid;
   // The d path corrects s by m in the opposite direction to the s path.
   assign d_sub    = ~mode;

   mod_addsub_word #(.K(K)) u_s_path (
      .a    (in_x),
      .b    (in_y),
      .sub  (mode),
      .cin  (c_s),
      .sum  (s_word),
      .cout (s_co)
   );

   mod_addsub_word #(.K(K)) u_d_path (
      .a    (s_word),
      .b    (in_m),
      .sub  (d_sub),
      .cin  (c_d),
      .sum  (d_word),
      .cout (d_co)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = LOAD;
         LOAD:    if (consume && last_cnt) state_nx = DECIDE;
         DECIDE:  state_nx = OUT;
         OUT:     if (last_cnt) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         mode  <= 1'b0;
         c_s   <= 1'b0;
         c_d   <= 1'b0;
         sel   <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (start) begin
                  mode <= op_sub;
                  cnt  <= '0;
                  c_s  <= 1'b0;
                  c_d  <= 1'b0;
               end
            end
            LOAD: begin
               if (in_valid) begin
                  c_s <= s_co;
                  c_d <= d_co;
                  cnt <= last_cnt ? '0 : cnt + 1'b1;
               end
            end
            DECIDE: begin
               // Add: s >= m shows up as a carry out of x+y or no borrow in s-m.
               // Sub: a borrow out of x-y means s went negative and needs +m.
               sel <= mode ? c_s : (c_s | ~c_d);
            end
            OUT: begin
               cnt <= last_cnt ? '0 : cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Buffers carry no reset; their contents are only read after a full load.
   always_ff @(posedge clk) begin
      if (consume) begin
         s_buf[cnt] <= s_word;
         d_buf[cnt] <= d_word;
      end
   end

   assign out_valid = (state == OUT);
   assign out_last  = out_valid && last_cnt;
   assign busy      = (state != IDLE);

   always_comb begin
      out_result = '0;
      if (out_valid) out_result = sel ? d_buf[cnt] : s_buf[cnt];
   end

endmodule

// File: tb/tb_mod_addsub_ws.sv
module tb_mod_addsub_ws;

   localparam int unsigned SK = 8;
   localparam int unsigned SN = 4;
   localparam int unsigned BK = 128;
   localparam int unsigned BN = 32;
   localparam int unsigned BW = BK * BN;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // small instance (K=8, N=4)
   logic          start = 1'b0, op_sub = 1'b0, in_valid = 1'b0;
   logic [SK-1:0] in_x = '0, in_y = '0, in_m = '0;
   logic [SK-1:0] out_result;
   logic          out_valid, out_last, busy;

   // default-size instance
   logic          bstart = 1'b0, bop = 1'b0, bvalid = 1'b0;
   logic [BK-1:0] bx = '0, by = '0, bm = '0;
   logic [BK-1:0] b_res;
   logic          b_valid, b_last, b_busy;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mod_addsub_ws #(.K(SK), .N(SN)) dut (
      .clk(clk), .rst(rst), .start(start), .op_sub(op_sub),
      .in_x(in_x), .in_y(in_y), .in_m(in_m), .in_valid(in_valid),
      .out_result(out_result), .out_valid(out_valid),
      .out_last(out_last), .busy(busy)
   );

   mod_addsub_ws dut_big (
      .clk(clk), .rst(rst), .start(bstart), .op_sub(bop),
      .in_x(bx), .in_y(by), .in_m(bm), .in_valid(bvalid),
      .out_result(b_res), .out_valid(b_valid),
      .out_last(b_last), .busy(b_busy)
   );

   task automatic chk(input logic [127:0] obs, input logic [127:0] exp, input string tag);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // gap: insert 1..3 idle cycles before each word; xstart: extra start
   // (with flipped mode) during the first gap; start_last: pulse start on
   // the out_last cycle.
   task automatic run_small(input logic sub, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] m, input logic [31:0] exp,
                            input bit gap, input bit xstart, input bit start_last,
                            input string tag);
      logic [31:0] got;
      got = '0;
      start = 1'b1; op_sub = sub;
      step();
      start = 1'b0;
      for (int w = 0; w < 4; w++) begin
         if (gap) begin
            for (int g = 0; g <= (w % 3); g++) begin
               if (xstart && w == 0 && g == 0) begin
                  start = 1'b1; op_sub = ~sub;
               end
               step();
               start = 1'b0; op_sub = sub;
            end
         end
         in_x = x[w*8 +: 8]; in_y = y[w*8 +: 8]; in_m = m[w*8 +: 8];
         in_valid = 1'b1;
         step();
         in_valid = 1'b0;
      end
      // one edge after the final word was consumed
      chk(out_valid, 1'b0, {tag, "_lat1"});
      chk(busy, 1'b1, {tag, "_busy"});
      step();
      for (int w = 0; w < 4; w++) begin
         chk(out_valid, 1'b1, $sformatf("%s_valid%0d", tag, w));
         chk(out_last, (w == 3), $sformatf("%s_last%0d", tag, w));
         got[w*8 +: 8] = out_result;
         if (w == 3 && start_last) start = 1'b1;
         step();
         start = 1'b0;
      end
      chk(got, exp, {tag, "_result"});
      chk(out_valid, 1'b0, {tag, "_done_valid"});
      chk(out_result, '0, {tag, "_done_zero"});
      chk(busy, 1'b0, {tag, "_done_busy"});
   endtask

   task automatic run_big(input int idx);
      logic [BW-1:0] x, y, m, exp;
      logic [BW:0]   t;
      logic          sub;
      int            n;
      for (int w = 0; w < BW / 32; w++) begin
         m[w*32 +: 32] = $urandom;
         x[w*32 +: 32] = $urandom;
         y[w*32 +: 32] = $urandom;
      end
      m[BW-1] = 1'b1;
      x[BW-1] = 1'b0;
      y[BW-1] = 1'b0;
      sub = 1'($urandom_range(1, 0));
      if (!sub) begin
         t = {1'b0, x} + {1'b0, y};
         if (t >= {1'b0, m}) t = t - {1'b0, m};
      end else begin
         if (x >= y) t = {1'b0, x} - {1'b0, y};
         else        t = {1'b0, x} + {1'b0, m} - {1'b0, y};
      end
      exp = t[BW-1:0];
      bstart = 1'b1; bop = sub;
      step();
      bstart = 1'b0;
      for (int w = 0; w < BN; w++) begin
         bx = x[w*BK +: BK]; by = y[w*BK +: BK]; bm = m[w*BK +: BK];
         bvalid = 1'b1;
         step();
      end
      bvalid = 1'b0;
      n = 0;
      while (!b_valid && n < 10) begin
         step();
         n++;
      end
      if (!b_valid) begin
         chk(b_valid, 1'b1, $sformatf("big%0d_timeout", idx));
         return;
      end
      for (int w = 0; w < BN; w++) begin
         chk(b_res, exp[w*BK +: BK], $sformatf("big%0d_w%0d", idx, w));
         if (w == BN - 1) chk(b_last, 1'b1, $sformatf("big%0d_last", idx));
         step();
      end
      chk(b_busy, 1'b0, $sformatf("big%0d_idle", idx));
   endtask

   initial begin
      rst = 1'b1;
      step();
      step();
      chk(out_valid, 1'b0, "rst_valid");
      chk(out_last, 1'b0, "rst_last");
      chk(busy, 1'b0, "rst_busy");
      chk(out_result, '0, "rst_result");
      chk(b_busy, 1'b0, "rst_bbusy");
      rst = 1'b0;
      step();

      // x+y exceeds m: reduced through the d path
      run_small(1'b0, 32'h00010000, 32'h00000010, 32'h00010007, 32'h00000009, 0, 0, 0, "add_over");
      // x+y below m: s path, start on the out_last cycle is ignored
      run_small(1'b0, 32'h00010000, 32'h00000006, 32'h00010007, 32'h00010006, 0, 0, 1, "add_s");
      run_small(1'b0, 32'h00010000, 32'h00000009, 32'h00010007, 32'h00000002, 0, 0, 0, "add_d");
      // x+y == m exactly
      run_small(1'b0, 32'h00010000, 32'h00000007, 32'h00010007, 32'h00000000, 0, 0, 0, "add_eq");
      run_small(1'b1, 32'h00000005, 32'h00000009, 32'h00010007, 32'h00010003, 0, 0, 0, "sub_neg");
      run_small(1'b1, 32'h00000009, 32'h00000005, 32'h00010007, 32'h00000004, 0, 0, 0, "sub_pos");
      run_small(1'b1, 32'h00001234, 32'h00001234, 32'h00010007, 32'h00000000, 0, 0, 0, "sub_zero");
      run_small(1'b0, 32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFB, 32'hFFFFFFF9, 0, 0, 0, "add_carry");
      // in_valid gaps plus a stray start during LOAD
      run_small(1'b0, 32'h00010000, 32'h00000009, 32'h00010007, 32'h00000002, 1, 1, 0, "add_gaps");

      // abort after two words; rst wins over start/in_valid in the same cycle
      start = 1'b1; op_sub = 1'b0;
      step();
      start = 1'b0;
      for (int w = 0; w < 2; w++) begin
         in_x = 8'h11; in_y = 8'h22; in_m = 8'h77; in_valid = 1'b1;
         step();
      end
      rst = 1'b1; start = 1'b1;
      step();
      rst = 1'b0; start = 1'b0; in_valid = 1'b0;
      chk(busy, 1'b0, "abort_busy");
      for (int c = 0; c < 6; c++) begin
         chk(out_valid, 1'b0, $sformatf("abort_valid%0d", c));
         step();
      end
      run_small(1'b0, 32'h00010000, 32'h00000009, 32'h00010007, 32'h00000002, 0, 0, 0, "after_abort");

      for (int i = 0; i < 50; i++) run_big(i);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
